// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_pkg
//  Description : Shared forwarding-select encodings and interlock FSM states
//                for the ID-stage hazard controller.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_ctrl_pkg;

    // Operand source select driven to the ID/EX operand muxes
    localparam logic [1:0] FWD_FILE = 2'd0;
    localparam logic [1:0] FWD_EX   = 2'd1;
    localparam logic [1:0] FWD_ME   = 2'd2;
    localparam logic [1:0] FWD_WB   = 2'd3;

    // Interlock cause, registered for observability
    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_LD_STALL = 2'd1,
        HZ_MDU_WAIT = 2'd2,
        HZ_FLUSH    = 2'd3
    } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_fwd_sel
//  Description : Priority match of one ID source operand against the EX, ME
//                and WB destinations (youngest producer wins).
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl_fwd_sel
    import hazard_ctrl_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] i_addr,
    input  logic          i_use,
    input  logic          i_ex_we,
    input  logic [AW-1:0] i_ex_wa,
    input  logic          i_me_we,
    input  logic [AW-1:0] i_me_wa,
    input  logic          i_wb_we,
    input  logic [AW-1:0] i_wb_wa,
    output logic [1:0]    o_sel,
    output logic          o_ex_hit
);

    logic w_valid;
    logic w_ex_hit;
    logic w_me_hit;
    logic w_wb_hit;

    // Register 0 is hardwired, so it never creates a dependency
    assign w_valid  = i_use && (i_addr != '0);
    assign w_ex_hit = w_valid && i_ex_we && (i_ex_wa == i_addr);
    assign w_me_hit = w_valid && i_me_we && (i_me_wa == i_addr);
    assign w_wb_hit = w_valid && i_wb_we && (i_wb_wa == i_addr);

    // Youngest matching producer selects the operand source
    always_comb begin
        o_sel = FWD_FILE;
        if (w_ex_hit)
            o_sel = FWD_EX;
        else if (w_me_hit)
            o_sel = FWD_ME;
        else if (w_wb_hit)
            o_sel = FWD_WB;
    end

    assign o_ex_hit = w_ex_hit;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : ID-stage interlock controller: operand forwarding selects,
//                load-use / MDU stalls, branch flush, and a single-entry
//                scoreboard for the multi-cycle MDU result.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int AW      = 5,
    parameter int MDU_LAT = 4,
    parameter int CW      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_id_r1_addr,
    input  logic [AW-1:0] i_id_r2_addr,
    input  logic          i_id_r1_use,
    input  logic          i_id_r2_use,
    input  logic          i_ex_we,
    input  logic [AW-1:0] i_ex_wa,
    input  logic          i_ex_is_load,
    input  logic          i_me_we,
    input  logic [AW-1:0] i_me_wa,
    input  logic          i_wb_we,
    input  logic [AW-1:0] i_wb_wa,
    input  logic          i_mdu_start,
    input  logic [AW-1:0] i_mdu_wa,
    input  logic          i_br_taken,
    output logic [1:0]    o_fwd_sel1,
    output logic [1:0]    o_fwd_sel2,
    output logic          o_stall,
    output logic          o_bubble_ex,
    output logic          o_flush_id,
    output logic          o_mdu_busy,
    output logic [1:0]    o_dbg_state
);

    localparam logic [CW-1:0] c_CNT_LOAD = CW'(MDU_LAT - 1);

    hz_state_t     r_state;
    hz_state_t     w_next;
    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_sb_wa;

    logic [1:0]    w_sel1;
    logic [1:0]    w_sel2;
    logic          w_ex_hit1;
    logic          w_ex_hit2;
    logic          w_load_use;
    logic          w_sb_hit1;
    logic          w_sb_hit2;
    logic          w_mdu_pending;
    logic          w_mdu_dep;
    logic          w_mdu_conf;
    logic          w_stall;
    logic          w_bubble;
    logic          w_flush;
    logic          w_accept;

    hazard_ctrl_fwd_sel #(.AW(AW)) u_fwd1 (
        .i_addr   (i_id_r1_addr),
        .i_use    (i_id_r1_use),
        .i_ex_we  (i_ex_we),
        .i_ex_wa  (i_ex_wa),
        .i_me_we  (i_me_we),
        .i_me_wa  (i_me_wa),
        .i_wb_we  (i_wb_we),
        .i_wb_wa  (i_wb_wa),
        .o_sel    (w_sel1),
        .o_ex_hit (w_ex_hit1)
    );

    hazard_ctrl_fwd_sel #(.AW(AW)) u_fwd2 (
        .i_addr   (i_id_r2_addr),
        .i_use    (i_id_r2_use),
        .i_ex_we  (i_ex_we),
        .i_ex_wa  (i_ex_wa),
        .i_me_we  (i_me_we),
        .i_me_wa  (i_me_wa),
        .i_wb_we  (i_wb_we),
        .i_wb_wa  (i_wb_wa),
        .o_sel    (w_sel2),
        .o_ex_hit (w_ex_hit2)
    );

    // A load in EX cannot be forwarded yet; the EX hit already includes ex_we
    assign w_load_use = i_ex_is_load && (w_ex_hit1 || w_ex_hit2);

    assign w_sb_hit1 = i_id_r1_use && (i_id_r1_addr != '0) && (i_id_r1_addr == r_sb_wa);
    assign w_sb_hit2 = i_id_r2_use && (i_id_r2_addr != '0) && (i_id_r2_addr == r_sb_wa);

    // In the final busy cycle (cnt==0) the result is in writeback and can be
    // forwarded, and the unit is free to accept the next op.
    assign w_mdu_pending = r_busy && (r_cnt != '0);
    assign w_mdu_dep     = w_mdu_pending && (w_sb_hit1 || w_sb_hit2);
    assign w_mdu_conf    = i_mdu_start && w_mdu_pending;

    // Next-state cause and interlock outputs, branch flush has top priority
    always_comb begin
        w_next   = HZ_RUN;
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        w_flush  = 1'b0;
        if (i_br_taken) begin
            w_next   = HZ_FLUSH;
            w_flush  = 1'b1;
            w_bubble = 1'b1;
        end else if (w_load_use) begin
            w_next   = HZ_LD_STALL;
            w_stall  = 1'b1;
            w_bubble = 1'b1;
        end else if (w_mdu_dep || w_mdu_conf) begin
            w_next   = HZ_MDU_WAIT;
            w_stall  = 1'b1;
            w_bubble = 1'b1;
        end
    end

    // Interlock cause register, kept for debug visibility
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= HZ_RUN;
        else
            r_state <= w_next;
    end

    // A branch does not cancel the in-flight MDU op, only a new issue
    assign w_accept = i_mdu_start && !w_stall && !i_br_taken;

    // MDU scoreboard: destination, busy flag and saturating countdown
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_sb_wa <= '0;
        end else if (w_accept) begin
            r_busy  <= 1'b1;
            r_cnt   <= c_CNT_LOAD;
            r_sb_wa <= i_mdu_wa;
        end else if (r_busy) begin
            if (r_cnt == '0)
                r_busy <= 1'b0;
            else
                r_cnt <= r_cnt - 1'b1;
        end
    end

    // Every output is forced quiet while reset is asserted
    assign o_fwd_sel1  = rst ? w_sel1 : FWD_FILE;
    assign o_fwd_sel2  = rst ? w_sel2 : FWD_FILE;
    assign o_stall     = rst && w_stall;
    assign o_bubble_ex = rst && w_bubble;
    assign o_flush_id  = rst && w_flush;
    assign o_mdu_busy  = rst && r_busy;
    assign o_dbg_state = rst ? r_state : HZ_RUN;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Directed self-checking bench for hazard_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] id_r1_addr, id_r2_addr, ex_wa, me_wa, wb_wa, mdu_wa;
    logic          id_r1_use, id_r2_use, ex_we, ex_is_load, me_we, wb_we;
    logic          mdu_start, br_taken;
    logic [1:0]    fwd_sel1, fwd_sel2, dbg_state;
    logic          stall, bubble_ex, flush_id, mdu_busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] exp_q[$];
    string      tag_q[$];

    hazard_ctrl #(.AW(AW), .MDU_LAT(4), .CW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_id_r1_addr (id_r1_addr),
        .i_id_r2_addr (id_r2_addr),
        .i_id_r1_use  (id_r1_use),
        .i_id_r2_use  (id_r2_use),
        .i_ex_we      (ex_we),
        .i_ex_wa      (ex_wa),
        .i_ex_is_load (ex_is_load),
        .i_me_we      (me_we),
        .i_me_wa      (me_wa),
        .i_wb_we      (wb_we),
        .i_wb_wa      (wb_wa),
        .i_mdu_start  (mdu_start),
        .i_mdu_wa     (mdu_wa),
        .i_br_taken   (br_taken),
        .o_fwd_sel1   (fwd_sel1),
        .o_fwd_sel2   (fwd_sel2),
        .o_stall      (stall),
        .o_bubble_ex  (bubble_ex),
        .o_flush_id   (flush_id),
        .o_mdu_busy   (mdu_busy),
        .o_dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic clr();
        id_r1_addr = '0; id_r2_addr = '0; id_r1_use = 1'b0; id_r2_use = 1'b0;
        ex_we = 1'b0; ex_wa = '0; ex_is_load = 1'b0;
        me_we = 1'b0; me_wa = '0; wb_we = 1'b0; wb_wa = '0;
        mdu_start = 1'b0; mdu_wa = '0; br_taken = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Expected = {fwd1, fwd2, stall, bubble, flush, busy, state}
    task automatic chk(input string tag, input logic [1:0] f1, input logic [1:0] f2,
                       input logic st, input logic bb, input logic fl, input logic by,
                       input logic [1:0] s, input bit now = 1'b0);
        logic [9:0] got;
        logic [9:0] e;
        string      t;
        exp_q.push_back({f1, f2, st, bb, fl, by, s});
        tag_q.push_back(tag);
        if (now) #1;
        else     @(negedge clk);
        got = {fwd_sel1, fwd_sel2, stall, bubble_ex, flush_id, mdu_busy, dbg_state};
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        n_checks++;
        assert (got === e) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", t, got, e);
        end
    endtask

    initial begin
        clr();
        rst = 1'b0;
        // Hazard-looking inputs during reset must not leak to the outputs
        ex_we = 1'b1; ex_wa = 5'd5; id_r1_addr = 5'd5; id_r1_use = 1'b1; br_taken = 1'b1;
        chk("reset", 2'd0, 2'd0, 0, 0, 0, 0, 2'd0);
        clr();
        rst = 1'b1;
        nxt();

        // Forwarding priority EX > ME > WB
        ex_we = 1'b1; ex_wa = 5'd5; me_we = 1'b1; me_wa = 5'd5; id_r1_addr = 5'd5; id_r1_use = 1'b1;
        chk("fwd_ex_over_me", 2'd1, 2'd0, 0, 0, 0, 0, 2'd0);
        nxt();
        ex_we = 1'b0; wb_we = 1'b1; wb_wa = 5'd5; id_r2_addr = 5'd5; id_r2_use = 1'b1;
        chk("fwd_me_over_wb", 2'd2, 2'd2, 0, 0, 0, 0, 2'd0);
        nxt();
        me_we = 1'b0; id_r2_use = 1'b0;
        chk("fwd_wb", 2'd3, 2'd0, 0, 0, 0, 0, 2'd0);
        nxt();

        // Register 0 never hazards
        clr();
        ex_we = 1'b1; ex_wa = 5'd0; ex_is_load = 1'b1; id_r1_addr = 5'd0; id_r1_use = 1'b1;
        chk("r0_no_hazard", 2'd0, 2'd0, 0, 0, 0, 0, 2'd0);
        nxt();

        // Load-use: one stall cycle, then forward from ME
        clr();
        ex_we = 1'b1; ex_is_load = 1'b1; ex_wa = 5'd7; id_r2_addr = 5'd7; id_r2_use = 1'b1;
        chk("load_use_stall", 2'd0, 2'd1, 1, 1, 0, 0, 2'd0);
        nxt();
        ex_we = 1'b0; ex_is_load = 1'b0; me_we = 1'b1; me_wa = 5'd7;
        chk("load_fwd_me", 2'd0, 2'd2, 0, 0, 0, 0, 2'd1);
        nxt();

        // MDU dependency: stall for 3 cycles, busy for 4
        clr();
        mdu_start = 1'b1; mdu_wa = 5'd9;
        chk("mdu_issue", 2'd0, 2'd0, 0, 0, 0, 0, 2'd0);
        nxt();
        mdu_start = 1'b0; id_r1_addr = 5'd9; id_r1_use = 1'b1;
        chk("mdu_wait_c3", 2'd0, 2'd0, 1, 1, 0, 1, 2'd0);
        nxt();
        chk("mdu_wait_c2", 2'd0, 2'd0, 1, 1, 0, 1, 2'd2);
        nxt();
        chk("mdu_wait_c1", 2'd0, 2'd0, 1, 1, 0, 1, 2'd2);
        nxt();
        chk("mdu_wb_c0", 2'd0, 2'd0, 0, 0, 0, 1, 2'd2);
        nxt();
        chk("mdu_done", 2'd0, 2'd0, 0, 0, 0, 0, 2'd0);
        nxt();

        // Branch overrides a load-use stall
        clr();
        ex_we = 1'b1; ex_is_load = 1'b1; ex_wa = 5'd7; id_r2_addr = 5'd7; id_r2_use = 1'b1; br_taken = 1'b1;
        chk("branch_flush", 2'd0, 2'd1, 0, 1, 1, 0, 2'd0);
        nxt();
        clr();
        chk("after_flush", 2'd0, 2'd0, 0, 0, 0, 0, 2'd3);
        nxt();

        // Structural conflict; new op accepted in the cycle busy clears
        mdu_start = 1'b1; mdu_wa = 5'd10;
        chk("conf_issue", 2'd0, 2'd0, 0, 0, 0, 0, 2'd0);
        nxt();
        chk("conf_c3", 2'd0, 2'd0, 1, 1, 0, 1, 2'd0);
        nxt();
        chk("conf_c2", 2'd0, 2'd0, 1, 1, 0, 1, 2'd2);
        nxt();
        chk("conf_c1", 2'd0, 2'd0, 1, 1, 0, 1, 2'd2);
        nxt();
        chk("conf_accept_c0", 2'd0, 2'd0, 0, 0, 0, 1, 2'd2);
        nxt();
        mdu_start = 1'b0;
        chk("conf_new_busy", 2'd0, 2'd0, 0, 0, 0, 1, 2'd0);
        repeat (3) nxt();
        nxt();
        chk("conf_drain", 2'd0, 2'd0, 0, 0, 0, 0, 2'd0);
        nxt();

        // Asynchronous reset in the middle of an MDU wait
        mdu_start = 1'b1; mdu_wa = 5'd9;
        chk("rst_issue", 2'd0, 2'd0, 0, 0, 0, 0, 2'd0);
        nxt();
        mdu_start = 1'b0; id_r1_addr = 5'd9; id_r1_use = 1'b1;
        chk("rst_wait_c3", 2'd0, 2'd0, 1, 1, 0, 1, 2'd0);
        nxt();
        chk("rst_wait_c2", 2'd0, 2'd0, 1, 1, 0, 1, 2'd2);
        #1 rst = 1'b0;
        chk("rst_mid_wait", 2'd0, 2'd0, 0, 0, 0, 0, 2'd0, 1'b1);
        rst = 1'b1;
        chk("rst_released", 2'd0, 2'd0, 0, 0, 0, 0, 2'd0, 1'b1);
        nxt();
        clr();
        chk("rst_run", 2'd0, 2'd0, 0, 0, 0, 0, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
